// File: rtl/sram_controller_pkg.sv
// Shared SRAM link constants, state encoding and address helper.
// Also the source of the cache controller's line-width constants.
package sram_pkg;

    localparam int SRAM_AW  = 18;
    localparam int SRAM_DW  = 16;
    localparam int RD_BEATS = 4;
    localparam int WR_BEATS = 2;
    localparam int WORD_W   = 32;
    localparam int LINE_W   = 64;

    localparam logic [31:0] ADDR_BASE_DEF = 32'd1024;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_e;

    // Word index into SRAM; bits above the 17-bit word space wrap away.
    function automatic logic [16:0] word_addr(
        input logic [31:0] a,
        input logic [31:0] base
    );
        return 17'((a - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Request/response link between the cache controller and the SRAM controller.
interface sram_controller_if;
    import sram_pkg::*;

    logic              r_en;
    logic              w_en;
    logic [31:0]       address;
    logic [WORD_W-1:0] write_data;
    logic [LINE_W-1:0] read_data;
    logic              ready;

    modport master (
        output r_en, w_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  r_en, w_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_controller.sv
// Serves one cache read (64-bit block) or write (32-bit word)
// over a 16-bit asynchronous SRAM, stalling the requester meanwhile.
module sram_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE     = ADDR_BASE_DEF,
    parameter int          ACCESS_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam logic [2:0] WAIT_LAST = 3'(ACCESS_CYCLES - 1);
    localparam logic [1:0] RD_LAST   = 2'(RD_BEATS - 1);
    localparam logic [1:0] WR_LAST   = 2'(WR_BEATS - 1);

    state_e            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [2:0]        wait_q, wait_d;
    logic [16:0]       wa_q, wa_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic               last_wait;
    logic               busy;
    logic [1:0]         beat_last;
    logic               we;
    logic [SRAM_DW-1:0] dq_out;

    assign last_wait = (wait_q == WAIT_LAST);
    assign busy      = (state_q == ST_RD) || (state_q == ST_WR);
    assign beat_last = (state_q == ST_RD) ? RD_LAST : WR_LAST;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        wa_d      = wa_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        SRAM_ADDR = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.r_en || bus.w_en) begin
                    wa_d    = word_addr(bus.address, ADDR_BASE);
                    wdata_d = bus.write_data;
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = bus.w_en ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                SRAM_ADDR = {wa_q[16:1], beat_q};
                if (last_wait)
                    rdata_d[{beat_q, 4'b0000} +: SRAM_DW] = SRAM_DQ;
            end
            ST_WR: begin
                SRAM_ADDR = {wa_q, beat_q[0]};
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase

        // Beat sequencing shared by both transfer directions.
        if (busy) begin
            if (last_wait) begin
                wait_d = '0;
                beat_d = beat_q + 2'd1;
                if (beat_q == beat_last) begin
                    beat_d  = '0;
                    state_d = ST_DONE;
                end
            end else begin
                wait_d = wait_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
            wa_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            wa_q    <= wa_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign we     = (state_q == ST_WR);
    assign dq_out = beat_q[0] ? wdata_q[31:16] : wdata_q[15:0];

    assign SRAM_DQ   = we ? dq_out : 16'bz;
    assign SRAM_WE_N = ~we;
    assign SRAM_OE_N = ~(state_q == ST_RD);
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign bus.read_data = rdata_q;
    assign bus.ready     = ((state_q == ST_IDLE) && !bus.r_en && !bus.w_en)
                         || (state_q == ST_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Random and directed bench for sram_controller against word-level memory models.
module tb_sram_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        sel3 = 1'b0;
    logic        r_en = 1'b0;
    logic        w_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;

    sram_controller_if b0();
    sram_controller_if b3();

    assign b0.r_en = r_en & ~sel3;
    assign b0.w_en = w_en & ~sel3;
    assign b3.r_en = r_en & sel3;
    assign b3.w_en = w_en & sel3;
    assign b0.address = addr;
    assign b3.address = addr;
    assign b0.write_data = wdata;
    assign b3.write_data = wdata;

    wire [15:0] dq0, dq3;
    logic [17:0] a0, a3;
    logic we0, oe0, ce0, ub0, lb0;
    logic we3, oe3, ce3, ub3, lb3;

    sram_controller #(.ACCESS_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave),
        .SRAM_DQ(dq0), .SRAM_ADDR(a0),
        .SRAM_WE_N(we0), .SRAM_OE_N(oe0),
        .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
    );

    sram_controller #(.ACCESS_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(b3.slave),
        .SRAM_DQ(dq3), .SRAM_ADDR(a3),
        .SRAM_WE_N(we3), .SRAM_OE_N(oe3),
        .SRAM_CE_N(ce3), .SRAM_UB_N(ub3), .SRAM_LB_N(lb3)
    );

    // Behavioural 2^18 x 16 SRAMs with a backdoor poke port.
    logic [15:0] mem0 [0:262143];
    logic [15:0] mem3 [0:262143];
    logic        p_en = 1'b0;
    logic        p_sel = 1'b0;
    logic [17:0] p_addr = '0;
    logic [15:0] p_val = '0;

    assign dq0 = (!oe0 && we0) ? mem0[a0] : 16'bz;
    assign dq3 = (!oe3 && we3) ? mem3[a3] : 16'bz;

    always @(posedge clk) begin
        if (p_en && !p_sel) mem0[p_addr] <= p_val;
        else if (!we0)      mem0[a0] <= dq0;
    end

    always @(posedge clk) begin
        if (p_en && p_sel) mem3[p_addr] <= p_val;
        else if (!we3)     mem3[a3] <= dq3;
    end

    wire        rdy_s = sel3 ? b3.ready : b0.ready;
    wire [63:0] rd_s  = sel3 ? b3.read_data : b0.read_data;
    wire [17:0] adr_s = sel3 ? a3 : a0;
    wire        we_s  = sel3 ? we3 : we0;
    wire        oe_s  = sel3 ? oe3 : oe0;

    // Reference: word-granular memory contents per SRAM.
    logic [31:0] refw  [int];
    logic [31:0] refw3 [int];
    logic [63:0] last_rd = '0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] wa_of(input logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'd1024) >> 2;
        return off[16:0];
    endfunction

    function automatic logic [31:0] ref_get(input bit s, input int k);
        if (s) return refw3.exists(k) ? refw3[k] : 32'h0;
        return refw.exists(k) ? refw[k] : 32'h0;
    endfunction

    task automatic poke_hw(input bit s, input logic [17:0] ha,
                           input logic [15:0] v);
        @(negedge clk);
        p_en = 1'b1; p_sel = s; p_addr = ha; p_val = v;
        @(posedge clk);
        #1 p_en = 1'b0;
    endtask

    task automatic poke_word(input bit s, input int k, input logic [31:0] v);
        logic [17:0] ha;
        ha = {k[16:0], 1'b0};
        poke_hw(s, ha, v[15:0]);
        poke_hw(s, ha | 18'd1, v[31:16]);
        if (s) refw3[k] = v;
        else   refw[k] = v;
    endtask

    // One request; mode 0 read, 1 write, 2 both enables.
    task automatic do_op(input int mode, input logic [31:0] a,
                         input logic [31:0] d, input bit b2b,
                         input bit hold, input string tag);
        int ac, beats, lat, nwe, noe, nbad;
        logic [17:0] aq [$];
        logic [16:0] wa;
        logic [17:0] ea;
        bit wr;
        logic [31:0] lo, hi;
        int b;
        wr    = (mode != 0);
        ac    = sel3 ? 3 : 1;
        beats = wr ? 2 : 4;
        wa    = wa_of(a);
        if (!b2b) @(negedge clk);
        r_en = (mode != 1); w_en = (mode != 0); addr = a; wdata = d;
        if (b2b) @(negedge clk);
        #1 check({tag, ":ready_drop"}, rdy_s, 1'b0);
        lat = 0; nwe = 0; noe = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (rdy_s || lat >= 100) break;
            aq.push_back(adr_s);
            if (!we_s) nwe++;
            if (!oe_s) noe++;
        end
        if (!rdy_s) check({tag, ":timeout"}, 1'b0, 1'b1);
        check({tag, ":latency"}, lat, beats * ac + 1);
        check({tag, ":we_done"}, we_s, 1'b1);
        check({tag, ":we_cycles"}, nwe, wr ? beats * ac : 0);
        check({tag, ":oe_cycles"}, noe, wr ? 0 : beats * ac);
        nbad = (aq.size() == beats * ac) ? 0 : 1;
        for (int i = 0; i < aq.size() && i < beats * ac; i++) begin
            b  = i / ac;
            ea = wr ? {wa, b[0]} : {wa[16:1], b[1:0]};
            if (aq[i] !== ea) nbad++;
        end
        check({tag, ":addr_seq"}, nbad, 0);
        if (wr) begin
            if (sel3) refw3[int'(wa)] = d;
            else      refw[int'(wa)] = d;
            check({tag, ":rd_hold"}, rd_s, last_rd);
        end else begin
            lo = ref_get(sel3, int'({wa[16:1], 1'b0}));
            hi = ref_get(sel3, int'({wa[16:1], 1'b1}));
            check({tag, ":rdata"}, rd_s, {hi, lo});
            last_rd = {hi, lo};
        end
        if (!hold) begin
            r_en = 1'b0; w_en = 1'b0;
        end
    endtask

    initial begin
        int mode, k;
        logic [31:0] a, d, v0, v1;

        #2;
        check("rst_ready", b0.ready, 1'b1);
        check("rst_pins", {we0, oe0}, 2'b11);
        check("rst_addr", a0, 18'd0);
        check("rst_rdata", b0.read_data, 64'd0);
        check("ce_ub_lb", {ce0, ub0, lb0}, 3'b000);
        @(negedge clk);
        rst = 1'b0;

        do_op(1, 32'd1024, 32'hDEADBEEF, 0, 0, "t1");
        check("t1:hw0", mem0[0], 16'hBEEF);
        check("t1:hw1", mem0[1], 16'hDEAD);

        poke_word(0, 0, 32'h2222_1111);
        poke_word(0, 1, 32'h4444_3333);
        do_op(0, 32'd1028, 32'h0, 0, 0, "t2");
        check("t2:block", b0.read_data, 64'h4444_3333_2222_1111);

        v0 = $urandom(); v1 = $urandom();
        poke_word(1, 0, v0);
        poke_word(1, 1, v1);
        sel3 = 1'b1;
        do_op(0, 32'd1024, 32'h0, 0, 0, "t3");
        sel3 = 1'b0;
        last_rd = b0.read_data;

        do_op(2, 32'd1032, 32'h0000CAFE, 0, 0, "t4");
        check("t4:hw4", mem0[4], 16'hCAFE);
        check("t4:hw5", mem0[5], 16'h0000);

        poke_word(0, 0, 32'hAAAA_5555);
        @(negedge clk);
        w_en = 1'b1; addr = 32'd1024; wdata = 32'h1357_9BDF;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        w_en = 1'b0;
        #1;
        check("t5:we_n", we0, 1'b1);
        check("t5:oe_n", oe0, 1'b1);
        check("t5:ready", b0.ready, 1'b1);
        check("t5:addr", a0, 18'd0);
        check("t5:hw0", mem0[0], 16'h9BDF);
        check("t5:hw1", mem0[1], 16'hAAAA);
        @(negedge clk);
        rst = 1'b0;
        refw[0] = 32'hAAAA_9BDF;
        last_rd = '0;
        do_op(0, 32'd1024, 32'h0, 0, 0, "t5rd");

        for (int i = 0; i < 32; i++) poke_word(0, i, $urandom());

        do_op(1, 32'd1040, 32'h1234_5678, 0, 1, "t6wr");
        do_op(0, 32'd1044, 32'h0, 1, 0, "t6rd");
        check("t6:lo", b0.read_data[31:0], 32'h1234_5678);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 2);
            k = $urandom_range(0, 31);
            a = 32'd1024 + 32'(k * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a + ($urandom() << 19);
            d = $urandom();
            do_op(mode, a, d, 0, 0, $sformatf("rnd%0d", i));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
